table_writer: RTL and testbench

//  Write-side master for the 30x40 tile table (4b tiles, dual-port RAM write port).

---
 rtl/table_writer.sv | 116 +++++++++++
 tb/tb_table_writer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/table_writer.sv
// table_writer: write-port master for the rows x cols tile table; single-tile write or whole-table fill.
// Latency: the write is driven the cycle after accept; done marks the final write. Backpressure: cmd_ready only in IDLE.
// Optional TABLE_WRITER_BOUNDS_CHECK_EN: out-of-range single writes are dropped and flagged with err+done.
module table_writer #(
    parameter int rows       = 30,
    parameter int cols       = 40,
    parameter int addr_width = 11,
    parameter int nsprites   = 4,
    parameter int row_width  = 5,
    parameter int col_width  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [row_width-1:0]  cmd_row,
    input  logic [col_width-1:0]  cmd_col,
    input  logic [nsprites-1:0]   cmd_tile,
    output logic                  ram_we,
    output logic [addr_width-1:0] ram_waddr,
    output logic [nsprites-1:0]   ram_din,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {IDLE, SINGLE, FILL} state_t;

    localparam logic [addr_width-1:0] last_addr = addr_width'(rows * cols - 1);

    state_t                state, state_nxt;
    logic                  we_nxt, busy_nxt, done_nxt, err_nxt;
    logic [addr_width-1:0] waddr_nxt;
    logic [nsprites-1:0]   din_nxt;

    assign cmd_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ram_we    <= 1'b0;
            ram_waddr <= '0;
            ram_din   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            ram_we    <= we_nxt;
            ram_waddr <= waddr_nxt;
            ram_din   <= din_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
        end
    end

    // Outputs are computed one cycle ahead so the registered write lines up with the state it belongs to.
    always_comb begin
        state_nxt = state;
        we_nxt    = 1'b0;
        waddr_nxt = ram_waddr;
        din_nxt   = ram_din;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    busy_nxt = 1'b1;
                    if (cmd_op) begin
                        state_nxt = FILL;
                        we_nxt    = 1'b1;
                        waddr_nxt = '0;
                        din_nxt   = cmd_tile;
                        done_nxt  = (last_addr == '0);
                    end else begin
                        state_nxt = SINGLE;
                        done_nxt  = 1'b1;
`ifdef TABLE_WRITER_BOUNDS_CHECK_EN
                        if ((32'(cmd_row) >= 32'(rows)) || (32'(cmd_col) >= 32'(cols))) begin
                            err_nxt = 1'b1;
                        end else begin
                            we_nxt    = 1'b1;
                            waddr_nxt = addr_width'(32'(cmd_row) * 32'(cols) + 32'(cmd_col));
                            din_nxt   = cmd_tile;
                        end
`else
                        we_nxt    = 1'b1;
                        waddr_nxt = addr_width'(32'(cmd_row) * 32'(cols) + 32'(cmd_col));
                        din_nxt   = cmd_tile;
`endif
                    end
                end
            end
            SINGLE: begin
                state_nxt = IDLE;
            end
            FILL: begin
                if (ram_waddr == last_addr) begin
                    state_nxt = IDLE;
                end else begin
                    we_nxt    = 1'b1;
                    busy_nxt  = 1'b1;
                    waddr_nxt = ram_waddr + 1'b1;
                    done_nxt  = (waddr_nxt == last_addr);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_table_writer.sv
// Scoreboarded bench for table_writer: a spec-level model queues every expected output event,
// a negedge monitor pops and compares; a RAM model built from the write port is checked against the model table.
module tb_table_writer;

    localparam int n_rows  = 30;
    localparam int n_cols  = 40;
    localparam int n_tiles = n_rows * n_cols;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_op;
    logic [4:0]  cmd_row;
    logic [5:0]  cmd_col;
    logic [3:0]  cmd_tile;
    logic        ram_we, busy, done, err;
    logic [10:0] ram_waddr;
    logic [3:0]  ram_din;

    always #5 clk = ~clk;

    table_writer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_tile(cmd_tile),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_din(ram_din),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        bit we;
        bit er;
        bit dn;
        int addr;
        int din;
    } exp_t;

    exp_t     exp_q[$];
    logic [3:0] dut_ram [2048] = '{default: 4'h0};
    logic [3:0] ref_ram [2048] = '{default: 4'h0};
    int total = 0;
    int bad   = 0;

    always @(posedge clk) begin
        if (ram_we) dut_ram[ram_waddr] <= ram_din;
    end

    exp_t mon_e;
    bit   mon_ok;
    always @(negedge clk) begin
        if (rst_n && (ram_we || done || err)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output: we=%0b err=%0b done=%0b addr=%0d din=%0h, required no event",
                         ram_we, err, done, ram_waddr, ram_din);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_ok = (ram_we == mon_e.we) && (err == mon_e.er) && (done == mon_e.dn) &&
                         (!mon_e.we || (int'(ram_waddr) == mon_e.addr && int'(ram_din) == mon_e.din));
                if (!mon_ok) begin
                    bad++;
                    $display("FAIL write_event: we=%0b err=%0b done=%0b addr=%0d din=%0h, required we=%0b err=%0b done=%0b addr=%0d din=%0h",
                             ram_we, err, done, ram_waddr, ram_din,
                             mon_e.we, mon_e.er, mon_e.dn, mon_e.addr, mon_e.din);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Reference: which writes a command produces and what the table holds afterwards.
    // keep = number of fill writes that actually land (less than n_tiles only when reset cuts a fill short).
    task automatic model_cmd(input bit op, input int row, input int col, input int tile, input int keep);
        exp_t e;
        int   a;
        if (op) begin
            for (int i = 0; i < n_tiles; i++) begin
                e = '{we: 1'b1, er: 1'b0, dn: (i == n_tiles - 1), addr: i, din: tile};
                exp_q.push_back(e);
                if (i < keep) ref_ram[i] = 4'(tile);
            end
        end else begin
`ifdef TABLE_WRITER_BOUNDS_CHECK_EN
            if (row >= n_rows || col >= n_cols) begin
                e = '{we: 1'b0, er: 1'b1, dn: 1'b1, addr: 0, din: 0};
                exp_q.push_back(e);
                return;
            end
`endif
            a = (row * n_cols + col) % 2048;
            e = '{we: 1'b1, er: 1'b0, dn: 1'b1, addr: a, din: tile};
            exp_q.push_back(e);
            ref_ram[a] = 4'(tile);
        end
    endtask

    task automatic drive(input bit v, input bit op, input int row, input int col, input int tile);
        cmd_valid = v;
        cmd_op    = op;
        cmd_row   = 5'(row);
        cmd_col   = 6'(col);
        cmd_tile  = 4'(tile);
    endtask

    // Called at a negedge. Presents a command, waits for acceptance, then presents the "next" inputs
    // while counting how many cycles cmd_ready stays low.
    task automatic issue(input bit op, input int row, input int col, input int tile, input int exp_low,
                         input bit nv, input bit nop, input int nrow, input int ncol, input int ntile);
        int n;
        drive(1'b1, op, row, col, tile);
        n = 0;
        while (!cmd_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: cmd_ready=0 after %0d cycles, required 1", n);
            return;
        end
        model_cmd(op, row, col, tile, n_tiles);
        @(negedge clk);
        check("busy_after_accept", int'(busy), 1);
        drive(nv, nop, nrow, ncol, ntile);
        n = 0;
        while (!cmd_ready && n < 3000) begin
            n++;
            @(negedge clk);
        end
        check("ready_low_cycles", n, exp_low);
        check("busy_when_ready", int'(busy), 0);
    endtask

    function automatic int ram_mismatches();
        int m = 0;
        for (int i = 0; i < 2048; i++) if (dut_ram[i] !== ref_ram[i]) m++;
        return m;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit op;
        drive(1'b0, 1'b0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({ram_we, busy, done, err, ram_waddr, ram_din}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", int'(cmd_ready), 1);
        check("busy_after_reset", int'(busy), 0);

        // Single write (2,5) -> 85
        issue(1'b0, 2, 5, 10, 1, 1'b0, 1'b0, 0, 0, 0);
        check("hold_waddr", int'(ram_waddr), 85);
        check("hold_din", int'(ram_din), 10);
        check("idle_we", int'(ram_we), 0);

        // Full fill with tile 3
        issue(1'b1, 0, 0, 3, n_tiles, 1'b0, 1'b0, 0, 0, 0);
        check("fill_last_cell", int'(dut_ram[n_tiles - 1]), 3);
        check("fill_first_cell", int'(dut_ram[0]), 3);

        // Single write held pending through a fill
        issue(1'b1, 0, 0, 7, n_tiles, 1'b1, 1'b0, 0, 0, 1);
        issue(1'b0, 0, 0, 1, 1, 1'b0, 1'b0, 0, 0, 0);
        check("pending_readback_0", int'(dut_ram[0]), 1);
        check("pending_readback_1", int'(dut_ram[1]), 7);

        // Row just past the table
        issue(1'b0, 30, 0, 9, 1, 1'b0, 1'b0, 0, 0, 0);
`ifdef TABLE_WRITER_BOUNDS_CHECK_EN
        check("oob_cell_1200", int'(dut_ram[1200]), 0);
`else
        check("oob_cell_1200", int'(dut_ram[1200]), 9);
`endif
        check("ram_after_directed", ram_mismatches(), 0);

        // Randomised command stream
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            op = ($urandom_range(0, 11) == 0);
            issue(op, $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 15),
                  op ? n_tiles : 1, 1'b0, 1'b0, 0, 0, 0);
        end
        check("ram_after_random", ram_mismatches(), 0);

        // Reset while the fill is presenting address 600
        drive(1'b1, 1'b1, 0, 0, 12);
        n = 0;
        while (!cmd_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        model_cmd(1'b1, 0, 0, 12, 600);
        @(negedge clk);
        drive(1'b0, 1'b0, 0, 0, 0);
        n = 0;
        while (!(ram_we && ram_waddr == 11'd600) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_600", int'(ram_waddr), 600);
        #2 rst_n = 1'b0;
        #1;
        check("abort_we_drop", int'(ram_we), 0);
        check("abort_outputs_zero", int'({busy, done, err, ram_waddr, ram_din}), 0);
        check("abort_pending_writes", exp_q.size(), n_tiles - 601);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_abort", int'(cmd_ready), 1);
        check("abort_cell_599", int'(dut_ram[599]), 12);
        check("ram_after_abort", ram_mismatches(), 0);

        for (int i = 0; i < 8; i++) begin
            issue(1'b0, $urandom_range(0, 29), $urandom_range(0, 39), $urandom_range(0, 15), 1,
                  1'b0, 1'b0, 0, 0, 0);
        end
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("ram_final", ram_mismatches(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
